// File: rtl/mpmc10_pkg.sv
// mpmc10_pkg: shared controller constants and timeout-monitor state encoding.
package mpmc10_pkg;
    localparam logic [3:0] IDLE = 4'd0;
    localparam int DWELL_W = 10;
    localparam logic [DWELL_W-1:0] DWELL_MAX = '1;
    typedef enum logic [1:0] {TM_WATCH, TM_ABORT, TM_RECOVER, TM_FATAL} mpmc10_tomon_state_t;
endpackage

// File: rtl/mpmc10_dwell_cnt.sv
// mpmc10_dwell_cnt: counts consecutive cycles the controller holds one non-idle state.
module mpmc10_dwell_cnt
    import mpmc10_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [3:0]         state,
    output logic [DWELL_W-1:0] dwell_d,
    output logic               dwell_adv
);
    logic [3:0]         prev_state_q;
    logic [DWELL_W-1:0] dwell_q;
    always_comb begin
        dwell_d   = (state == IDLE || state != prev_state_q) ? '0 :
                    (dwell_q == DWELL_MAX) ? dwell_q : dwell_q + 1'b1;
        // A held saturated count must not re-match the limit
        dwell_adv = dwell_d != dwell_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_state_q <= IDLE;
            dwell_q      <= '0;
        end else begin
            prev_state_q <= state;
            dwell_q      <= dwell_d;
        end
    end
endmodule

// File: rtl/mpmc10_timeout_mon.sv
// mpmc10_timeout_mon: flags controller stalls, requests an abort, and escalates
// to a sticky fatal flag if the controller does not recover in time.
module mpmc10_timeout_mon
    import mpmc10_pkg::*;
#(
    parameter int ACK_TMO = 64,
    parameter int EVW     = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [3:0]     state,
    input  logic [9:0]     timeout_lim,
    input  logic           abort_ack,
    output logic           abort_req,
    output logic           timeout,
    output logic [3:0]     stuck_state,
    output logic [EVW-1:0] to_events,
    output logic           fatal
);
    localparam int WW = $clog2(ACK_TMO + 1);
    localparam logic [WW-1:0] WAIT_MAX = WW'(ACK_TMO);

    mpmc10_tomon_state_t fsm_q, fsm_d;
    logic [WW-1:0]       wait_q, wait_d, wait_inc;
    logic [3:0]          stuck_q, stuck_d;
    logic [EVW-1:0]      ev_q, ev_d;
    logic                timeout_q, timeout_d, abort_req_q, abort_req_d, fatal_q, fatal_d;
    logic [DWELL_W-1:0]  dwell_d;
    logic                dwell_adv, hit;

    mpmc10_dwell_cnt u_dwell (
        .clk       (clk),
        .rst       (rst),
        .state     (state),
        .dwell_d   (dwell_d),
        .dwell_adv (dwell_adv)
    );

    always_comb begin
        // Equality on a freshly advanced count: lowering the limit below dwell never fires
        hit       = timeout_lim != '0 && state != IDLE && dwell_adv && dwell_d == timeout_lim;
        wait_inc  = wait_q + 1'b1;
        fsm_d     = fsm_q;
        wait_d    = wait_q;
        stuck_d   = stuck_q;
        ev_d      = ev_q;
        timeout_d = 1'b0;
        unique case (fsm_q)
            TM_WATCH: if (hit) begin
                fsm_d     = TM_ABORT;
                wait_d    = '0;
                timeout_d = 1'b1;
                stuck_d   = state;
                ev_d      = (&ev_q) ? ev_q : ev_q + 1'b1;
            end
            TM_ABORT: begin
                wait_d = abort_ack ? '0 : wait_inc;
                fsm_d  = abort_ack ? TM_RECOVER : (wait_inc == WAIT_MAX) ? TM_FATAL : TM_ABORT;
            end
            TM_RECOVER: begin
                wait_d = (state == IDLE) ? '0 : wait_inc;
                fsm_d  = (state == IDLE) ? TM_WATCH : (wait_inc == WAIT_MAX) ? TM_FATAL : TM_RECOVER;
            end
            default: ;
        endcase
        abort_req_d = fsm_d == TM_ABORT;
        fatal_d     = fsm_d == TM_FATAL;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q       <= TM_WATCH;
            wait_q      <= '0;
            stuck_q     <= '0;
            ev_q        <= '0;
            timeout_q   <= 1'b0;
            abort_req_q <= 1'b0;
            fatal_q     <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            wait_q      <= wait_d;
            stuck_q     <= stuck_d;
            ev_q        <= ev_d;
            timeout_q   <= timeout_d;
            abort_req_q <= abort_req_d;
            fatal_q     <= fatal_d;
        end
    end

    assign abort_req   = abort_req_q;
    assign timeout     = timeout_q;
    assign stuck_state = stuck_q;
    assign to_events   = ev_q;
    assign fatal       = fatal_q;
endmodule

// File: tb/tb_mpmc10_timeout_mon.sv
// tb_mpmc10_timeout_mon: table vectors, directed corner sequences and random
// stimulus checked against a run-length reference model.
module tb_mpmc10_timeout_mon;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1, abort_ack = 1'b0;
    logic [3:0] state = 4'd0;
    logic [9:0] timeout_lim = 10'd0;
    logic       abort_req, timeout, fatal, abort_req2, timeout2, fatal2;
    logic [3:0] stuck_state, stuck_state2;
    logic [7:0] to_events;
    logic [1:0] to_events2;

    mpmc10_timeout_mon #(.ACK_TMO(64), .EVW(8)) dut (
        .clk(clk), .rst(rst), .state(state), .timeout_lim(timeout_lim), .abort_ack(abort_ack),
        .abort_req(abort_req), .timeout(timeout), .stuck_state(stuck_state),
        .to_events(to_events), .fatal(fatal));

    mpmc10_timeout_mon #(.ACK_TMO(64), .EVW(2)) dut2 (
        .clk(clk), .rst(rst), .state(state), .timeout_lim(timeout_lim), .abort_ack(abort_ack),
        .abort_req(abort_req2), .timeout(timeout2), .stuck_state(stuck_state2),
        .to_events(to_events2), .fatal(fatal2));

    int vecs = 0, errs = 0;

    localparam int M_WATCH = 0, M_ABORT = 1, M_RECOVER = 2, M_FATAL = 3;
    int m_run = 0, m_prev = 0, m_mode = M_WATCH, m_wait = 0;
    int m_stuck = 0, m_ev = 0, m_ev2 = 0, m_to = 0;

    // Run length is unbounded; the limit matches only the first time the run reaches it.
    task automatic model();
        int rn;
        if (rst) begin
            m_run = 0; m_prev = 0; m_mode = M_WATCH; m_wait = 0;
            m_stuck = 0; m_ev = 0; m_ev2 = 0; m_to = 0;
        end else begin
            rn = (state == 0 || int'(state) != m_prev) ? 0 : m_run + 1;
            m_to = 0;
            if (m_mode == M_WATCH) begin
                if (timeout_lim != 0 && state != 0 && rn == int'(timeout_lim)) begin
                    m_to = 1; m_stuck = int'(state); m_mode = M_ABORT; m_wait = 0;
                    m_ev = (m_ev < 255) ? m_ev + 1 : 255;
                    m_ev2 = (m_ev2 < 3) ? m_ev2 + 1 : 3;
                end
            end else if (m_mode == M_ABORT) begin
                if (abort_ack) begin
                    m_mode = M_RECOVER; m_wait = 0;
                end else begin
                    m_wait++;
                    if (m_wait == 64) m_mode = M_FATAL;
                end
            end else if (m_mode == M_RECOVER) begin
                if (state == 0) m_mode = M_WATCH;
                else begin
                    m_wait++;
                    if (m_wait == 64) m_mode = M_FATAL;
                end
            end
            m_run = rn;
            m_prev = int'(state);
        end
    endtask

    task automatic chk(input string n, input int act, input int exp);
        vecs++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d at %0t", n, act, exp, $time);
        end
    endtask

    task automatic step(input logic r, input logic [3:0] s, input logic [9:0] l, input logic a);
        rst = r; state = s; timeout_lim = l; abort_ack = a;
        @(posedge clk);
        model();
        #1;
        chk("timeout", int'(timeout), m_to);
        chk("abort_req", int'(abort_req), int'(m_mode == M_ABORT));
        chk("fatal", int'(fatal), int'(m_mode == M_FATAL));
        chk("stuck_state", int'(stuck_state), m_stuck);
        chk("to_events", int'(to_events), m_ev);
        chk("to_events_evw2", int'(to_events2), m_ev2);
        chk("timeout_evw2", int'(timeout2), m_to);
    endtask

    task automatic hold_until_to(input logic [3:0] s, input logic [9:0] l, input int budget, output int k);
        k = -1;
        for (int i = 0; i < budget; i++) begin
            step(1'b0, s, l, 1'b0);
            if (timeout) begin
                k = i;
                break;
            end
        end
    endtask

    typedef struct {
        logic       r;
        logic [3:0] s;
        logic [9:0] l;
        logic       a;
        logic       eto, ear, efat;
        int         eev;
    } vec_t;

    vec_t tbl[14];

    initial begin
        int k, n, cnt;
        logic [3:0] rs;
        logic [9:0] rl;
        tbl[0]  = '{1'b0, 4'd3, 10'd2, 1'b0, 1'b0, 1'b0, 1'b0, 0};
        tbl[1]  = '{1'b0, 4'd3, 10'd2, 1'b0, 1'b0, 1'b0, 1'b0, 0};
        tbl[2]  = '{1'b0, 4'd3, 10'd2, 1'b0, 1'b1, 1'b1, 1'b0, 1};
        tbl[3]  = '{1'b0, 4'd3, 10'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1};
        tbl[4]  = '{1'b0, 4'd3, 10'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1};
        tbl[5]  = '{1'b0, 4'd3, 10'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1};
        tbl[6]  = '{1'b0, 4'd0, 10'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1};
        tbl[7]  = '{1'b0, 4'd5, 10'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1};
        tbl[8]  = '{1'b0, 4'd5, 10'd1, 1'b1, 1'b1, 1'b1, 1'b0, 2};
        tbl[9]  = '{1'b0, 4'd5, 10'd1, 1'b0, 1'b0, 1'b1, 1'b0, 2};
        tbl[10] = '{1'b1, 4'd5, 10'd1, 1'b0, 1'b0, 1'b0, 1'b0, 0};
        tbl[11] = '{1'b0, 4'd5, 10'd1, 1'b0, 1'b0, 1'b0, 1'b0, 0};
        tbl[12] = '{1'b0, 4'd5, 10'd1, 1'b0, 1'b1, 1'b1, 1'b0, 1};
        tbl[13] = '{1'b0, 4'd5, 10'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1};

        step(1'b1, 4'd9, 10'd5, 1'b1);
        step(1'b1, 4'd9, 10'd5, 1'b1);
        chk("reset_outputs", int'({abort_req, timeout, stuck_state, to_events, fatal}), 0);

        for (int i = 0; i < 14; i++) begin
            step(tbl[i].r, tbl[i].s, tbl[i].l, tbl[i].a);
            chk("tbl_timeout", int'(timeout), int'(tbl[i].eto));
            chk("tbl_abort_req", int'(abort_req), int'(tbl[i].ear));
            chk("tbl_fatal", int'(fatal), int'(tbl[i].efat));
            chk("tbl_events", int'(to_events), tbl[i].eev);
        end

        // Basic stall: 10-cycle limit, then slow ack and return to idle
        step(1'b1, 4'd0, 10'd0, 1'b0);
        hold_until_to(4'd3, 10'd10, 20, k);
        chk("stall_latency", k, 10);
        chk("stall_stuck", int'(stuck_state), 3);
        chk("stall_events", int'(to_events), 1);
        step(1'b0, 4'd3, 10'd10, 1'b0);
        chk("abort_req_next", int'(abort_req), 1);
        for (int i = 0; i < 3; i++) step(1'b0, 4'd3, 10'd10, 1'b0);
        step(1'b0, 4'd3, 10'd10, 1'b1);
        chk("abort_req_dropped", int'(abort_req), 0);
        step(1'b0, 4'd3, 10'd10, 1'b0);
        step(1'b0, 4'd3, 10'd10, 1'b0);
        step(1'b0, 4'd0, 10'd10, 1'b0);
        hold_until_to(4'd7, 10'd10, 20, k);
        chk("second_stall_latency", k, 10);
        chk("second_stall_events", int'(to_events), 2);

        // No ack: escalate to fatal after 64 cycles in ABORT
        n = -1;
        for (int i = 1; i <= 80; i++) begin
            step(1'b0, 4'd7, 10'd10, 1'b0);
            if (fatal) begin
                n = i;
                break;
            end
        end
        chk("fatal_latency", n, 64);
        chk("fatal_abort_req", int'(abort_req), 0);
        for (int i = 0; i < 5; i++) step(1'b0, 4'd0, 10'd1, 1'b1);
        chk("fatal_sticky", int'(fatal), 1);
        step(1'b1, 4'd7, 10'd3, 1'b1);
        chk("fatal_reset", int'({abort_req, timeout, stuck_state, to_events, fatal}), 0);
        hold_until_to(4'd2, 10'd3, 10, k);
        chk("resume_latency", k, 3);
        step(1'b0, 4'd2, 10'd3, 1'b1);
        step(1'b0, 4'd0, 10'd3, 1'b0);

        // Toggling states and long idle never stall
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            step(1'b0, (i % 2) ? 4'd4 : 4'd3, 10'd2, 1'b0);
            cnt += int'(timeout);
        end
        chk("toggle_no_timeout", cnt, 0);
        cnt = 0;
        for (int i = 0; i < 2000; i++) begin
            step(1'b0, 4'd0, 10'd1, 1'b0);
            cnt += int'(timeout);
        end
        chk("idle_no_timeout", cnt, 0);

        // Saturated dwell must not match a newly raised limit
        cnt = 0;
        for (int i = 0; i < 1500; i++) begin
            step(1'b0, 4'd2, 10'd0, 1'b0);
            cnt += int'(timeout);
        end
        for (int i = 0; i < 100; i++) begin
            step(1'b0, 4'd2, 10'd1023, 1'b0);
            cnt += int'(timeout);
        end
        chk("saturated_no_timeout", cnt, 0);
        step(1'b0, 4'd0, 10'd1023, 1'b0);
        hold_until_to(4'd2, 10'd1023, 1100, k);
        chk("max_limit_latency", k, 1023);
        step(1'b0, 4'd2, 10'd1023, 1'b1);
        step(1'b0, 4'd0, 10'd1023, 1'b0);

        // Event counter saturation on the narrow instance
        step(1'b1, 4'd0, 10'd0, 1'b0);
        for (int j = 0; j < 5; j++) begin
            hold_until_to(4'd1, 10'd1, 5, k);
            chk("evw_stall", k, 1);
            step(1'b0, 4'd1, 10'd1, 1'b1);
            step(1'b0, 4'd0, 10'd1, 1'b0);
        end
        chk("events_wide", int'(to_events), 5);
        chk("events_narrow_sat", int'(to_events2), 3);

        // Random traffic against the model
        rs = 4'd1;
        rl = 10'd3;
        step(1'b1, 4'd0, 10'd0, 1'b0);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(3) == 0) rs = 4'($urandom_range(3));
            if ($urandom_range(15) == 0) rl = 10'($urandom_range(5));
            step(1'b0 | ($urandom_range(399) == 0), rs, rl, $urandom_range(2) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
